// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg -- shared typedefs for the memory responder slice.
//   mem_state_t : responder FSM states (IDLE, WAIT, RESP)
//   opcode_t    : latched operation of the transaction in flight
//   states_t    : coarse transaction phase for external monitors
//   cnt_width() : wait-counter width, never below one bit
package mem_responder_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  typedef enum logic {OP_RD, OP_WR} opcode_t;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} states_t;

  // $clog2(1) is 0, so a zero wait still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array -- DWIDTH x 2**AWIDTH storage, synchronous write, combinational
// read, contents never reset.
//   clk   : write clock
//   we    : write enable
//   addr  : shared read/write word address
//   wdata : write data
//   rdata : combinational read data at addr
module mem_array #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder -- single-port memory slave with programmable wait states.
// A request strobe seen in IDLE is latched, WAIT_CYCLES wait states follow,
// then the operation commits and ack pulses for one cycle.
//   clk, rst_        : clock, asynchronous active-low reset
//   mem_rd, mem_wr   : request strobes (both high = write)
//   addr, data_in    : word address, write data
//   data_out         : registered read data, changes only when a read commits
//   ack              : one-cycle completion pulse
//   busy             : wait states in progress
//   err (MEM_ERR_EN) : pulses with ack when both strobes were high
// Optional feature macro: MEM_ERR_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              ack,
`ifdef MEM_ERR_EN
  output logic              err,
`endif
  output logic              busy
);

  localparam int CW = cnt_width(WAIT_CYCLES);

  mem_state_t        state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              commit;
  opcode_t           op;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;
  logic [DWIDTH-1:0] rdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: if (mem_rd || mem_wr) begin
        state_nxt = WAIT;
        cnt_nxt   = CW'(WAIT_CYCLES);
      end
      WAIT: if (cnt == '0) begin
        state_nxt = RESP;
        commit    = 1'b1;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy covers the counted wait states (nonzero counter); the final WAIT
  // cycle hands over to ack, so the two outputs can never overlap and a
  // zero-wait build never raises busy.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      cnt      <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= commit;
      busy  <= (state == WAIT) && (cnt != '0);
      if (commit && op == OP_RD) data_out <= rdata;
    end
  end

  // Request capture; only meaningful while a transaction is in flight.
  always_ff @(posedge clk)
    if (state == IDLE && (mem_rd || mem_wr)) begin
      op     <= mem_wr ? OP_WR : OP_RD;
      addr_q <= addr;
      data_q <= data_in;
    end

`ifdef MEM_ERR_EN
  logic both_q;

  always_ff @(posedge clk)
    if (state == IDLE && (mem_rd || mem_wr)) both_q <= mem_rd && mem_wr;

  always_ff @(posedge clk or negedge rst_)
    if (!rst_) err <= 1'b0;
    else       err <= commit && both_q;
`endif

  mem_array #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_mem (
    .clk   (clk),
    .we    (commit && op == OP_WR),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- two responders (WAIT_CYCLES 0 and 2) on shared stimulus,
// each checked against its own array-based reference model.
// Build with MEM_ERR_EN defined to also check err.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst_, rd, wr, en0;
  logic [4:0] addr;
  logic [7:0] din;
  logic       rd0, wr0;
  logic [1:0]      ack_v, busy_v;
  logic [1:0][7:0] dout_v;
`ifdef MEM_ERR_EN
  logic [1:0]      err_v;
`endif

  always #5 clk = ~clk;

  // Instance 0 can be masked off so that transactions only one side should
  // see (ignored strobes, aborted writes) stay off the zero-wait responder.
  assign rd0 = rd & en0;
  assign wr0 = wr & en0;

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_(rst_), .mem_rd(rd0), .mem_wr(wr0), .addr(addr),
    .data_in(din), .data_out(dout_v[0]), .ack(ack_v[0]),
`ifdef MEM_ERR_EN
    .err(err_v[0]),
`endif
    .busy(busy_v[0]));

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_(rst_), .mem_rd(rd), .mem_wr(wr), .addr(addr),
    .data_in(din), .data_out(dout_v[1]), .ack(ack_v[1]),
`ifdef MEM_ERR_EN
    .err(err_v[1]),
`endif
    .busy(busy_v[1]));

  int         wc [2] = '{0, 2};
  logic [7:0] mm [2][32];
  logic [7:0] dm [2];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_ack%0d", tag, i), 32'(ack_v[i]), 0);
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy_v[i]), 0);
      chk($sformatf("%s_dout%0d", tag, i), 32'(dout_v[i]), 0);
`ifdef MEM_ERR_EN
      chk($sformatf("%s_err%0d", tag, i), 32'(err_v[i]), 0);
`endif
    end
  endtask

  // One transaction sampled at edge N, observed after edges N..N+4.
  // inject: a read of addr 3 arrives while the 2-wait responder is busy.
  // rst_mid: reset pulled low mid-cycle during the wait states.
  task automatic txn(input bit r, input bit w, input logic [4:0] a,
                     input logic [7:0] d, input bit inject, input bit rst_mid);
    bit act [2];
    @(negedge clk);
    rd = r; wr = w; addr = a; din = d;
    en0 = !(inject || rst_mid);
    act[0] = en0;
    act[1] = 1'b1;
    if (!rst_mid)
      for (int i = 0; i < 2; i++)
        if (act[i]) begin
          if (w) mm[i][a] = d;
          else   dm[i] = mm[i][a];
        end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ack%0d_a%0d_k%0d", i, a, k), 32'(ack_v[i]),
            32'(act[i] && k == wc[i] + 1));
        chk($sformatf("busy%0d_a%0d_k%0d", i, a, k), 32'(busy_v[i]),
            32'(act[i] && k >= 1 && k <= wc[i]));
`ifdef MEM_ERR_EN
        chk($sformatf("err%0d_a%0d_k%0d", i, a, k), 32'(err_v[i]),
            32'(act[i] && r && w && k == wc[i] + 1));
`endif
        if (k >= 3)
          chk($sformatf("dout%0d_a%0d_k%0d", i, a, k), 32'(dout_v[i]), 32'(dm[i]));
      end
      if (inject && k == 1) begin rd = 1'b1; addr = 5'd3; end
      if (inject && k == 2) rd = 1'b0;
      if (rst_mid && k == 1) begin
        #3 rst_ = 1'b0;
        #1;
        dm[0] = '0;
        dm[1] = '0;
        act[1] = 1'b0;
        check_reset("rst_mid");
        #2 rst_ = 1'b1;
      end
    end
    en0 = 1'b1;
  endtask

  initial begin
    rst_ = 1'b0; rd = 1'b0; wr = 1'b0; en0 = 1'b1; addr = '0; din = '0;
    dm[0] = '0; dm[1] = '0;
    #12;
    check_reset("rst_init");
    @(negedge clk);
    rst_ = 1'b1;

    for (int a = 0; a < 32; a++) txn(0, 1, 5'(a), 8'($urandom), 0, 0);

    txn(0, 1, 5'd5, 8'hA5, 0, 0);
    txn(1, 0, 5'd5, 8'h00, 0, 0);
    txn(1, 0, 5'd0, 8'h00, 0, 0);
    txn(0, 1, 5'd7, 8'h5A, 1, 0);
    txn(1, 1, 5'd9, 8'h3C, 0, 0);
    txn(1, 0, 5'd9, 8'h00, 0, 0);
    txn(0, 1, 5'd2, 8'h11, 0, 0);
    txn(0, 1, 5'd2, 8'hFF, 0, 1);
    txn(1, 0, 5'd2, 8'h00, 0, 0);

    repeat (40) begin
      int op;
      op = $urandom_range(0, 2);
      txn(op != 1, op != 0, 5'($urandom), 8'($urandom), $urandom_range(0, 5) == 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter AWIDTH, default 5, address width (32 words).
REQ-002 SHALL have parameter DWIDTH, default 8, data word width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before ack; legal range 0..15.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port mem_rd  input  1  read request strobe from the controller.
REQ-007 SHALL have port mem_wr  input  1  write request strobe from the controller.
REQ-008 SHALL have port addr  input  AWIDTH  word address.
REQ-009 SHALL have port data_in  input  DWIDTH  write data.
REQ-010 SHALL have port data_out  output  DWIDTH  registered read data.
REQ-011 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  request in progress; new requests ignored.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP, held in a registered state variable of type mem_state_t.
REQ-014 IDLE: on a rising edge with mem_rd or mem_wr high, SHALL latch addr, data_in and operation, load the wait counter with WAIT_CYCLES, and go to WAIT.
REQ-015 WAIT: busy=1; counter 0 -> RESP on next edge; otherwise decrement the counter and stay.
REQ-016 Transition WAIT->RESP SHALL commit the operation: write stores the latched data at the latched addr; read loads data_out from the latched addr.
REQ-017 RESP: ack=1 for exactly one cycle, busy=0; next edge -> IDLE unconditionally.
REQ-018 Latency: a request sampled at edge N SHALL raise ack at edge N+1+WAIT_CYCLES; with WAIT_CYCLES=0 ack rises at edge N+1.
REQ-019 Requests SHALL be sampled only in IDLE; strobes during WAIT or RESP are ignored; a strobe still high in IDLE after RESP starts a new transaction.
REQ-020 mem_rd and mem_wr both high when sampled SHALL be treated as a write.
REQ-021 data_out SHALL hold its value until the next read commits; writes do not change it, even to the same address.
REQ-022 The wait counter SHALL be $clog2(WAIT_CYCLES+1) bits wide, minimum 1; it never wraps.
REQ-023 ack and busy SHALL be registered outputs, never both high.

Reset
REQ-024 rst_ low SHALL immediately force state=IDLE, ack=0, busy=0, data_out=0, counter=0 and err=0 when present.
REQ-025 Memory array contents SHALL NOT be reset.
REQ-026 Reset during WAIT SHALL abort the transaction: no write commits and no ack is issued.
REQ-027 The first request SHALL be sampled on the first rising edge after rst_ deasserts.

Configuration
REQ-028 With MEM_ERR_EN defined, SHALL add output err (1 bit), registered and pulsed together with ack when the transaction was sampled with both mem_rd and mem_wr high.
REQ-029 Without MEM_ERR_EN, the err port and its logic SHALL be absent; REQ-020 behaviour is unchanged.

Structure
REQ-030 mem_state_t (IDLE, WAIT, RESP) SHALL live in the shared typedefs package next to opcode_t and states_t.
REQ-031 The storage array SHALL be a sub-module mem_array: a DWIDTH x 2**AWIDTH array with a synchronous write port, a combinational read, and no reset.

Verification
REQ-032 Reset: assert rst_=0 mid-cycle -> data_out=0, ack=0, busy=0 immediately without a clock edge.
REQ-033 WAIT_CYCLES=2: write 8'hA5 to addr 5 at edge N -> busy during N+1..N+2, ack at N+3; then read addr 5 -> data_out=8'hA5 with ack at M+3.
REQ-034 WAIT_CYCLES=0: read addr 0 at edge N -> ack and data_out valid at N+1, busy never high.
REQ-035 Issue a read to addr 3 while busy on a write to addr 7 -> only one ack; addr 3 not read; data_out unchanged.
REQ-036 mem_rd=mem_wr=1, data_in=8'h3C, addr 9 -> memory[9]=8'h3C, data_out unchanged, err pulses with ack when MEM_ERR_EN is defined.
REQ-037 Write 8'hFF to addr 2 while addr 2 holds 8'h11, then pull rst_ low during WAIT -> no ack; a subsequent read of addr 2 returns 8'h11.
